// File: rtl/rect_sprite_mover.sv
// Single-sprite erase/move/draw controller for the 160x120 VGA framebuffer.
// Each accepted frame tick erases the sprite, steps it with clamping, and redraws it.

module rect_axis_step #(
  parameter int W     = 8,
  parameter int LIMIT = 144,
  parameter int STEP  = 1
) (
  input  logic [W-1:0] pos,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] nxt
);
  // One extra bit so the step can never wrap before it is clamped.
  localparam logic [W:0] LIM_E  = (W+1)'(LIMIT);
  localparam logic [W:0] STEP_E = (W+1)'(STEP);

  logic [W:0] ext, sum, diff;

  always_comb begin
    ext  = {1'b0, pos};
    sum  = ext + STEP_E;
    diff = ext - STEP_E;
    nxt  = pos;
    if (inc && !dec)
      nxt = (sum > LIM_E) ? LIM_E[W-1:0] : sum[W-1:0];
    else if (dec && !inc)
      nxt = (ext >= STEP_E) ? diff[W-1:0] : '0;
  end
endmodule

module rect_sprite_mover #(
  parameter int         X_W    = 8,
  parameter int         Y_W    = 7,
  parameter int         SCR_W  = 160,
  parameter int         SCR_H  = 120,
  parameter int         SPR_W  = 16,
  parameter int         SPR_H  = 2,
  parameter int         X_INIT = 50,
  parameter int         Y_INIT = 60,
  parameter int         STEP   = 1,
  parameter logic [2:0] FG     = 3'b111,
  parameter logic [2:0] BG     = 3'b000
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           frame_tick,
  input  logic           enable,
  input  logic           left,
  input  logic           right,
  input  logic           up,
  input  logic           down,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [2:0]     colour_out,
  output logic           plot,
  output logic           busy,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y
);
  typedef enum logic [2:0] {START, IDLE, ERASE, MOVE, DRAW} state_t;

  localparam logic [X_W-1:0] CX_LAST = X_W'(SPR_W - 1);
  localparam logic [Y_W-1:0] CY_LAST = Y_W'(SPR_H - 1);

  state_t         state;
  logic [X_W-1:0] cx, nx;
  logic [Y_W-1:0] cy, ny;
  logic           last_col, last_px;

  rect_axis_step #(.W(X_W), .LIMIT(SCR_W - SPR_W), .STEP(STEP)) u_step_x (
    .pos(pos_x), .dec(left), .inc(right), .nxt(nx)
  );
  rect_axis_step #(.W(Y_W), .LIMIT(SCR_H - SPR_H), .STEP(STEP)) u_step_y (
    .pos(pos_y), .dec(up), .inc(down), .nxt(ny)
  );

  assign x_out    = pos_x + cx;
  assign y_out    = pos_y + cy;
  assign busy     = (state != IDLE);
  assign last_col = (cx == CX_LAST);
  assign last_px  = last_col && (cy == CY_LAST);

  // plot/colour are registered alongside the state so they line up with the sweep counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= START;
      pos_x      <= X_W'(X_INIT);
      pos_y      <= Y_W'(Y_INIT);
      cx         <= '0;
      cy         <= '0;
      plot       <= 1'b0;
      colour_out <= BG;
    end else begin
      case (state)
        START: begin
          state      <= DRAW;
          plot       <= 1'b1;
          colour_out <= FG;
        end
        IDLE: begin
          if (frame_tick && enable) begin
            state      <= ERASE;
            plot       <= 1'b1;
            colour_out <= BG;
          end
        end
        ERASE, DRAW: begin
          if (last_px) begin
            cx    <= '0;
            cy    <= '0;
            plot  <= 1'b0;
            state <= (state == ERASE) ? MOVE : IDLE;
          end else if (last_col) begin
            cx <= '0;
            cy <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        MOVE: begin
          pos_x      <= nx;
          pos_y      <= ny;
          state      <= DRAW;
          plot       <= 1'b1;
          colour_out <= FG;
        end
        default: begin
          state <= START;
          plot  <= 1'b0;
        end
      endcase
    end
  end
endmodule
